// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel mode
// encoding, the stop divisor value and small width/arithmetic helpers.
package clk_div_pkg;

    // A divisor of zero parks a channel with both outputs low.
    localparam int unsigned DIV_STOP = 0;

    // What a channel does on the coming edge when neither reset nor sync is active.
    typedef enum logic [1:0] {
        CH_STOPPED,
        CH_HOLD,
        CH_COUNT,
        CH_WRAP
    } ch_mode_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Length of the high phase, ceil(d/2), formed without the d+1 overflow at max d.
    function automatic int unsigned half_ceil(input int unsigned d);
        return (d >> 1) + (d & 32'd1);
    endfunction

endpackage

// File: rtl/div_clk_channel.sv
// One divider channel: period counter, active divisor, pending divisor
// with its flag, and the registered divided-clock / tick outputs.
module div_clk_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_we,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_pend,
    output logic             o_dclk,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] STOP    = DIV_W'(DIV_STOP);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_CNT = (DEFAULT_DIV == 0) ? '0 : DIV_W'(DEFAULT_DIV - 1);

    // Terminal count for a divisor; a stopped channel sits at zero.
    function automatic logic [DIV_W-1:0] last_cnt(input logic [DIV_W-1:0] d);
        return (d == STOP) ? '0 : (d - ONE);
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_dclk;
    logic             r_tick;

    ch_mode_e         w_mode;
    logic [DIV_W-1:0] w_apply_div;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_pend_div_nxt;
    logic             w_pend_nxt;
    logic             w_dclk_nxt;
    logic             w_tick_nxt;

    // Classify the edge, then work out every next-state value; the pending
    // divisor is only consumed at a period boundary, a stop restart or a sync.
    always_comb begin
        w_apply_div    = r_pend ? r_pend_div : r_div;
        w_cnt_inc      = r_cnt + ONE;
        w_div_nxt      = r_div;
        w_cnt_nxt      = r_cnt;
        w_pend_div_nxt = r_pend_div;
        w_pend_nxt     = r_pend;
        w_dclk_nxt     = r_dclk;
        w_tick_nxt     = 1'b0;

        if (r_div == STOP) begin
            w_mode = CH_STOPPED;
        end else if (!i_en) begin
            w_mode = CH_HOLD;
        end else if (r_cnt == (r_div - ONE)) begin
            w_mode = CH_WRAP;
        end else begin
            w_mode = CH_COUNT;
        end

        if (i_sync) begin
            w_div_nxt  = w_apply_div;
            w_cnt_nxt  = last_cnt(w_apply_div);
            w_pend_nxt = 1'b0;
            w_dclk_nxt = 1'b0;
        end else begin
            case (w_mode)
                CH_STOPPED: begin
                    w_cnt_nxt  = '0;
                    w_dclk_nxt = 1'b0;
                    if (r_pend) begin
                        w_div_nxt  = r_pend_div;
                        w_cnt_nxt  = last_cnt(r_pend_div);
                        w_pend_nxt = 1'b0;
                    end
                end
                CH_COUNT: begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_dclk_nxt = (32'(w_cnt_inc) < half_ceil(32'(r_div)));
                end
                CH_WRAP: begin
                    w_div_nxt  = w_apply_div;
                    w_pend_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                    if (w_apply_div == STOP) begin
                        w_dclk_nxt = 1'b0;
                    end else begin
                        w_tick_nxt = 1'b1;
                        w_dclk_nxt = (half_ceil(32'(w_apply_div)) != 32'd0);
                    end
                end
                default: begin
                end
            endcase

            if (i_we) begin
                w_pend_div_nxt = i_div;
                w_pend_nxt     = 1'b1;
            end
        end
    end

    // Register channel state; reset drops any pending write and reloads the default divisor.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div      <= RST_DIV;
            r_cnt      <= RST_CNT;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_dclk     <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_div      <= w_div_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend     <= w_pend_nxt;
            r_dclk     <= w_dclk_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign o_pend = r_pend;
    assign o_dclk = r_dclk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes to one
// channel, broadcasts sync/reset and gathers the per-channel outputs.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int DIV_W       = 8,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = int'(ch_width(N_CH))
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_en,
    input  logic             i_sync,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic [N_CH-1:0]  o_cfg_pend,
    output logic [N_CH-1:0]  o_divided_clk,
    output logic [N_CH-1:0]  o_tick
);

    logic [N_CH-1:0] w_we;

    // One-hot write strobe; a select beyond the last channel matches nothing.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (i_cfg_we && (32'(i_cfg_ch) == 32'(i))) begin
                w_we[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        div_clk_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (i_en[g]),
            .i_sync (i_sync),
            .i_we   (w_we[g]),
            .i_div  (i_cfg_div),
            .o_pend (o_cfg_pend[g]),
            .o_dclk (o_divided_clk[g]),
            .o_tick (o_tick[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi built with three channels.
module tb_clk_divider_multi;

    localparam int NCH  = 3;
    localparam int DW   = 8;
    localparam int DEFD = 2;
    localparam int CW   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           cfgWe = 1'b0;
    logic [CW-1:0]  cfgCh = '0;
    logic [DW-1:0]  cfgDiv = '0;
    logic [NCH-1:0] cfgPend;
    logic [NCH-1:0] dclk;
    logic [NCH-1:0] tick;

    typedef struct {
        logic [NCH-1:0] pend;
        logic [NCH-1:0] dclk;
        logic [NCH-1:0] tick;
        int             cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monCur;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;

    // Reference model: divisor, position inside the current period
    // (-1 = waiting for a period to start), pending value/flag, outputs.
    int md[NCH];
    int mPos[NCH];
    int mPendV[NCH];
    bit mPend[NCH];
    bit mDclk[NCH];
    bit mTick[NCH];

    clk_divider_multi #(
        .N_CH        (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEFD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_sync        (sync),
        .i_cfg_we      (cfgWe),
        .i_cfg_ch      (cfgCh),
        .i_cfg_div     (cfgDiv),
        .o_cfg_pend    (cfgPend),
        .o_divided_clk (dclk),
        .o_tick        (tick)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge given the inputs present at that edge.
    task automatic modelStep(input bit r, input bit [NCH-1:0] e, input bit s,
                             input bit we, input int ch, input int dv);
        for (int c = 0; c < NCH; c++) begin
            mTick[c] = 1'b0;
            if (r) begin
                md[c] = DEFD; mPos[c] = -1; mPend[c] = 1'b0; mDclk[c] = 1'b0;
            end else if (s) begin
                if (mPend[c]) md[c] = mPendV[c];
                mPend[c] = 1'b0; mPos[c] = -1; mDclk[c] = 1'b0;
            end else begin
                if (md[c] == 0) begin
                    if (mPend[c]) begin md[c] = mPendV[c]; mPend[c] = 1'b0; end
                    mPos[c] = -1; mDclk[c] = 1'b0;
                end else if (e[c]) begin
                    if (mPos[c] == -1 || mPos[c] == md[c] - 1) begin
                        if (mPend[c]) begin md[c] = mPendV[c]; mPend[c] = 1'b0; end
                        if (md[c] == 0) begin
                            mPos[c] = -1; mDclk[c] = 1'b0;
                        end else begin
                            mPos[c] = 0; mTick[c] = 1'b1; mDclk[c] = 1'b1;
                        end
                    end else begin
                        mPos[c] = mPos[c] + 1;
                        mDclk[c] = (mPos[c] < (md[c] + 1) / 2);
                    end
                end
                if (we && ch == c) begin mPendV[c] = dv; mPend[c] = 1'b1; end
            end
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic applyStimulus(input bit r, input bit [NCH-1:0] e, input bit s,
                                 input bit we, input int ch, input int dv);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; sync = s; cfgWe = we; cfgCh = CW'(ch); cfgDiv = DW'(dv);
        modelStep(r, e, s, we, ch, dv);
        cycle++;
        for (int c = 0; c < NCH; c++) begin
            x.pend[c] = mPend[c]; x.dclk[c] = mDclk[c]; x.tick[c] = mTick[c];
        end
        x.cyc = cycle;
        expQ.push_back(x);
    endtask

    task automatic runCycles(input int n, input bit [NCH-1:0] e);
        for (int k = 0; k < n; k++) applyStimulus(0, e, 0, 0, 0, 0);
    endtask

    task automatic writeDiv(input bit [NCH-1:0] e, input int ch, input int dv);
        applyStimulus(0, e, 0, 1, ch, dv);
    endtask

    task automatic checkOutput(input string name, input int cyc,
                               input logic [NCH-1:0] act, input logic [NCH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, req);
        end
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monCur = expQ.pop_front();
            checkOutput("cfg_pend", monCur.cyc, cfgPend, monCur.pend);
            checkOutput("divided_clk", monCur.cyc, dclk, monCur.dclk);
            checkOutput("tick", monCur.cyc, tick, monCur.tick);
        end
    end

    initial begin
        bit [NCH-1:0] re;
        $display("[TB] start");
        // Reset held three cycles, then free-running default divide-by-2.
        for (int k = 0; k < 3; k++) applyStimulus(1, '1, 0, 0, 0, 0);
        runCycles(9, '1);
        // Channel 1 reprogrammed to 5 in the middle of a period.
        writeDiv('1, 1, 5);
        runCycles(16, '1);
        // Channel 2: divide-by-1, then stop, then restart at 4.
        writeDiv('1, 2, 1);
        runCycles(6, '1);
        writeDiv('1, 2, 0);
        runCycles(5, '1);
        writeDiv('1, 2, 4);
        runCycles(12, '1);
        // Channel 0 at 4, paused for three cycles while in its high phase.
        writeDiv('1, 0, 4);
        runCycles(7, '1);
        runCycles(3, 3'b110);
        runCycles(10, '1);
        // Channels 0/1 at 3 and 4, then phase-aligned by sync.
        writeDiv('1, 0, 3);
        writeDiv('1, 1, 4);
        runCycles(2, '1);
        applyStimulus(0, '1, 1, 0, 0, 0);
        runCycles(26, '1);
        // Out-of-range select, then reset while a write is pending.
        writeDiv('1, 3, 6);
        runCycles(3, '1);
        writeDiv('1, 0, 7);
        applyStimulus(1, '1, 0, 0, 0, 0);
        applyStimulus(1, '1, 0, 0, 0, 0);
        runCycles(8, '1);
        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            bit w, s, r;
            int dv, sel;
            for (int c = 0; c < NCH; c++) re[c] = ($urandom_range(0, 7) != 0);
            w = ($urandom_range(0, 5) == 0);
            s = !w && ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 149) == 0);
            sel = $urandom_range(0, 3);
            dv = $urandom_range(0, 9);
            if (dv == 9) dv = $urandom_range(0, 255);
            applyStimulus(r, re, s, w, sel, dv);
        end
        runCycles(2, '1);
        repeat (3) @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got=%0d expected=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
